// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage core. It decides
//            when the F/D stages freeze (stall) and when a bubble is loaded
//            into the D/E register (clr_E). Two stall sources are handled:
//              * register data hazards that forwarding cannot cover, i.e. the
//                D instruction needs an operand sooner than a producer in E
//                or M can deliver it (Tuse < Tnew);
//              * occupancy of the multi-cycle mult/div unit (MDU).
//            The block also owns the MDU busy counter and a saturating
//            count of stalled cycles for performance monitoring.
//            Producers with Tnew == 0 are left to the forwarding unit.
//
// Ports    :
//   clk          in   1   core clock
//   reset        in   1   synchronous, active-high
//   A1_D         in   5   rs index of the D-stage instruction
//   A2_D         in   5   rt index of the D-stage instruction
//   Tuse_RS_D    in   2   cycles until rs is consumed (3 = unused)
//   Tuse_RT_D    in   2   cycles until rt is consumed (3 = unused)
//   md_use_D     in   1   D instruction touches the MDU / HI / LO
//   A3_E         in   5   destination register of the E instruction
//   RegWrite_E   in   1   E instruction writes the register file
//   Tnew_E       in   2   E result ready in N cycles
//   A3_M         in   5   destination register of the M instruction
//   RegWrite_M   in   1   M instruction writes the register file
//   Tnew_M       in   2   M result ready in N cycles
//   md_start_E   in   1   mult/div issuing in E this cycle
//   md_is_div_E  in   1   1 = div, 0 = mult (qualifies md_start_E)
//   flush        in   1   exception / interrupt flush request
//   stall        out  1   freeze PC and F/D register
//   clr_E        out  1   load a bubble into D/E
//   md_busy      out  1   MDU occupied
//   stall_cycles out  32  saturating count of cycles with stall = 1
//
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [1:0]  Tuse_RS_D,
  input  logic [1:0]  Tuse_RT_D,
  input  logic        md_use_D,
  input  logic [4:0]  A3_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  Tnew_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        flush,
  output logic        stall,
  output logic        clr_E,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [1:0]       C_TUSE_NONE = 2'd3;
  localparam logic [31:0]      C_SC_MAX    = 32'hFFFF_FFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] mdu_cnt_q;
  logic [CNT_W-1:0] mdu_cnt_d;
  logic [31:0]      stall_cycles_q;
  logic [31:0]      stall_cycles_d;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic rs_live;
  logic rt_live;
  logic rs_hz_e;
  logic rs_hz_m;
  logic rt_hz_e;
  logic rt_hz_m;
  logic rs_hz;
  logic rt_hz;
  logic md_hz;
  logic hz_any;

  always_comb begin
    // An operand only matters if it names a real register ($0 is hardwired
    // to zero) and the instruction actually reads it (Tuse != 3).
    rs_live = (A1_D != 5'd0) && (Tuse_RS_D != C_TUSE_NONE);
    rt_live = (A2_D != 5'd0) && (Tuse_RT_D != C_TUSE_NONE);

    // A producer blocks the consumer when its result arrives later than the
    // consumer needs it. Tnew == 0 can never satisfy Tuse < Tnew, so
    // forwardable producers fall out of this comparison naturally.
    rs_hz_e = RegWrite_E && (A1_D == A3_E) && (Tuse_RS_D < Tnew_E);
    rs_hz_m = RegWrite_M && (A1_D == A3_M) && (Tuse_RS_D < Tnew_M);
    rt_hz_e = RegWrite_E && (A2_D == A3_E) && (Tuse_RT_D < Tnew_E);
    rt_hz_m = RegWrite_M && (A2_D == A3_M) && (Tuse_RT_D < Tnew_M);

    // Either stage alone is enough; the younger E match is not required to
    // shadow the M match here because both must be waited out anyway.
    rs_hz = rs_live && (rs_hz_e || rs_hz_m);
    rt_hz = rt_live && (rt_hz_e || rt_hz_m);

    // md_start_E counts as busy too: md_busy only rises the cycle after the
    // issue, so without it a back-to-back MDU instruction would slip through.
    md_hz = md_use_D && (md_busy || md_start_E);

    hz_any = rs_hz || rt_hz || md_hz;
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs (purely combinational, same-cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    // A flush wins over any stall: the F/D contents are being discarded, so
    // freezing them would be pointless; E still receives a bubble.
    stall = !reset && !flush && hz_any;
    clr_E = stall || flush;
  end

  // --------------------------------------------------------------------------
  // MDU occupancy counter
  // --------------------------------------------------------------------------
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (md_start_E && !flush && !reset) begin
      // A start while already busy simply reloads; the hazard logic keeps
      // this from happening in normal operation.
      mdu_cnt_d = md_is_div_E ? C_DIV_LOAD : C_MULT_LOAD;
    end else if (mdu_cnt_q != '0) begin
      // A flush does not abort an operation already in flight.
      mdu_cnt_d = mdu_cnt_q - 1'b1;
    end
  end

  assign md_busy = (mdu_cnt_q != '0);

  // --------------------------------------------------------------------------
  // Stall-cycle performance counter (saturating, never wraps)
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != C_SC_MAX)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed self-checking bench for hazard_stall_ctrl. Inputs are
//            applied 1 time unit after the rising edge, outputs are sampled
//            on the falling edge. Expected values are hand-derived; the
//            stall-cycle expectation is tracked in exp_sc.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  A1_D;
  logic [4:0]  A2_D;
  logic [1:0]  Tuse_RS_D;
  logic [1:0]  Tuse_RT_D;
  logic        md_use_D;
  logic [4:0]  A3_E;
  logic        RegWrite_E;
  logic [1:0]  Tnew_E;
  logic [4:0]  A3_M;
  logic        RegWrite_M;
  logic [1:0]  Tnew_M;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        flush;
  logic        stall;
  logic        clr_E;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_sc;

  hazard_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .A1_D         (A1_D),
    .A2_D         (A2_D),
    .Tuse_RS_D    (Tuse_RS_D),
    .Tuse_RT_D    (Tuse_RT_D),
    .md_use_D     (md_use_D),
    .A3_E         (A3_E),
    .RegWrite_E   (RegWrite_E),
    .Tnew_E       (Tnew_E),
    .A3_M         (A3_M),
    .RegWrite_M   (RegWrite_M),
    .Tnew_M       (Tnew_M),
    .md_start_E   (md_start_E),
    .md_is_div_E  (md_is_div_E),
    .flush        (flush),
    .stall        (stall),
    .clr_E        (clr_E),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    A1_D = 5'd0; A2_D = 5'd0; Tuse_RS_D = 2'd3; Tuse_RT_D = 2'd3;
    md_use_D = 1'b0;
    A3_E = 5'd0; RegWrite_E = 1'b0; Tnew_E = 2'd0;
    A3_M = 5'd0; RegWrite_M = 1'b0; Tnew_M = 2'd0;
    md_start_E = 1'b0; md_is_div_E = 1'b0; flush = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Cross the next rising edge; st is the stall value expected during the
  // cycle just finished, which decides whether stall_cycles advances.
  task automatic advance(input bit st);
    @(posedge clk);
    if (st && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
    #1;
  endtask

  // Watchdog: the directed sequence is short, so this only trips on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_sc   = 32'd0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- reset: a live hazard must not stall while reset is high --------
    A1_D = 5'd1; Tuse_RS_D = 2'd1; A3_E = 5'd1; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    sample();
    chk("rst_stall",   {31'd0, stall},   32'd0);
    chk("rst_clr",     {31'd0, clr_E},   32'd0);
    chk("rst_busy",    {31'd0, md_busy}, 32'd0);
    chk("rst_sc",      stall_cycles,     32'd0);
    advance(1'b0);
    reset = 1'b0;

    // ---- lw in E, addu rs=1 in D: Tuse 1 < Tnew 2 -> stall --------------
    sample();
    chk("lwE_stall",   {31'd0, stall},   32'd1);
    chk("lwE_clr",     {31'd0, clr_E},   32'd1);
    advance(1'b1);
    // lw now in M with Tnew 1; a consumer with Tuse 0 (branch) still waits.
    idle_inputs();
    A1_D = 5'd1; Tuse_RS_D = 2'd0; A3_M = 5'd1; RegWrite_M = 1'b1; Tnew_M = 2'd1;
    sample();
    chk("lwM_stall",   {31'd0, stall},   32'd1);
    advance(1'b1);
    idle_inputs();
    A1_D = 5'd1; Tuse_RS_D = 2'd0; A3_E = 5'd7; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    sample();
    chk("nomatch_stall", {31'd0, stall}, 32'd0);
    chk("nomatch_clr",   {31'd0, clr_E}, 32'd0);
    chk("sc_after2",   stall_cycles,     32'd2);
    advance(1'b0);

    // ---- $0 never stalls --------------------------------------------------
    idle_inputs();
    A1_D = 5'd0; Tuse_RS_D = 2'd0; A3_E = 5'd0; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    sample();
    chk("r0_stall",    {31'd0, stall},   32'd0);
    advance(1'b0);

    // ---- rt hazard from M; Tuse boundary cases ---------------------------
    idle_inputs();
    A2_D = 5'd5; Tuse_RT_D = 2'd0; A3_M = 5'd5; RegWrite_M = 1'b1; Tnew_M = 2'd1;
    sample();
    chk("rtM_stall",   {31'd0, stall},   32'd1);
    advance(1'b1);
    Tuse_RT_D = 2'd1;                       // Tuse == Tnew -> forwardable later
    sample();
    chk("rt_eq_stall", {31'd0, stall},   32'd0);
    advance(1'b0);
    idle_inputs();
    A2_D = 5'd9; Tuse_RT_D = 2'd3; A3_E = 5'd9; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    sample();
    chk("tuse3_stall", {31'd0, stall},   32'd0);
    advance(1'b0);
    Tuse_RT_D = 2'd0; RegWrite_E = 1'b0;    // no write -> no hazard
    sample();
    chk("nowr_stall",  {31'd0, stall},   32'd0);
    advance(1'b0);
    // E and M both target the same register; E alone is enough.
    idle_inputs();
    A1_D = 5'd3; Tuse_RS_D = 2'd1; A3_E = 5'd3; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    A3_M = 5'd3; RegWrite_M = 1'b1; Tnew_M = 2'd0;
    sample();
    chk("EM_stall",    {31'd0, stall},   32'd1);
    advance(1'b1);

    // ---- divide: busy t+1..t+10, mflo in D stalls t..t+10 ----------------
    idle_inputs();
    md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1;
    sample();
    chk("div_t_stall", {31'd0, stall},   32'd1);
    chk("div_t_busy",  {31'd0, md_busy}, 32'd0);
    advance(1'b1);
    md_start_E = 1'b0; md_is_div_E = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      sample();
      chk("div_busy",  {31'd0, md_busy}, 32'd1);
      chk("div_stall", {31'd0, stall},   32'd1);
      advance(1'b1);
    end
    sample();
    chk("div_end_busy",  {31'd0, md_busy}, 32'd0);
    chk("div_end_stall", {31'd0, stall},   32'd0);
    chk("div_sc",      stall_cycles,     exp_sc);
    advance(1'b0);

    // ---- multiply: busy exactly 5 cycles ---------------------------------
    idle_inputs();
    md_start_E = 1'b1; md_is_div_E = 1'b0;
    advance(1'b0);
    md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sample();
      chk("mul_busy",  {31'd0, md_busy}, 32'd1);
      advance(1'b0);
    end
    sample();
    chk("mul_end_busy", {31'd0, md_busy}, 32'd0);

    // ---- flush overrides a hazard; counter unchanged ---------------------
    idle_inputs();
    A1_D = 5'd4; Tuse_RS_D = 2'd0; A3_E = 5'd4; RegWrite_E = 1'b1; Tnew_E = 2'd1;
    flush = 1'b1;
    sample();
    chk("fl_stall",    {31'd0, stall},   32'd0);
    chk("fl_clr",      {31'd0, clr_E},   32'd1);
    advance(1'b0);
    idle_inputs();
    sample();
    chk("fl_sc",       stall_cycles,     exp_sc);

    // ---- flush with md_start suppresses the load -------------------------
    md_start_E = 1'b1; md_is_div_E = 1'b1; flush = 1'b1;
    sample();
    chk("flmd_clr",    {31'd0, clr_E},   32'd1);
    advance(1'b0);
    idle_inputs();
    sample();
    chk("flmd_busy",   {31'd0, md_busy}, 32'd0);

    // ---- reset mid-divide (counter at 6) ---------------------------------
    md_start_E = 1'b1; md_is_div_E = 1'b1;
    advance(1'b0);                          // counter 10
    idle_inputs();
    for (int i = 0; i < 4; i++) advance(1'b0);  // counter 6
    sample();
    chk("mid_busy",    {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    md_use_D = 1'b1;
    sample();
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    advance(1'b0);
    exp_sc = 32'd0;
    reset = 1'b0;
    idle_inputs();
    sample();
    chk("mid_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("mid_rst_sc",   stall_cycles,     32'd0);

    // ---- saturation of the stall-cycle counter ---------------------------
    A1_D = 5'd2; Tuse_RS_D = 2'd0; A3_E = 5'd2; RegWrite_E = 1'b1; Tnew_E = 2'd2;
    sample();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    exp_sc = 32'hFFFF_FFFE;
    advance(1'b1);
    sample();
    chk("sat_max",     stall_cycles,     32'hFFFF_FFFF);
    advance(1'b1);
    sample();
    chk("sat_hold",    stall_cycles,     32'hFFFF_FFFF);
    chk("sat_model",   stall_cycles,     exp_sc);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
